// File: rtl/nmr_seq_pkg.sv
// Shared types and constants for the two-pulse NMR sequencer.
// Imported by the sequencer top and its timer.
package nmr_seq_pkg;

    localparam int CNT_W_DEF  = 32;
    localparam int SHOT_W_DEF = 16;
    localparam int FRQ_W_DEF  = 32;

    localparam logic [1:0] PH_0   = 2'd0;
    localparam logic [1:0] PH_90  = 2'd1;
    localparam logic [1:0] PH_180 = 2'd2;
    localparam logic [1:0] PH_270 = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P1   = 3'd1,
        S_TAU  = 3'd2,
        S_P2   = 3'd3,
        S_ACQ  = 3'd4,
        S_REP  = 3'd5
    } state_e;

endpackage

// File: rtl/nmr_seq_timer.sv
// Loadable down-counter; expire is high during the last cycle of a load.
// A zero load expires at once so a forced one-cycle dwell works too.
module seq_timer
    import nmr_seq_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] len_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= len_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expire_o = (cnt_q <= W'(1));

endmodule

// File: rtl/nmr_pulse_sequencer.sv
// Two-pulse NMR timing engine feeding Signal_Generator (enable/frq/TX)
// plus the ADC acquisition gate; one shared timer reloaded per state.
module nmr_pulse_sequencer
    import nmr_seq_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int SHOT_W = SHOT_W_DEF,
    parameter int FRQ_W  = FRQ_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [FRQ_W-1:0]  cfg_frq,
    input  logic [CNT_W-1:0]  cfg_p1_len,
    input  logic [CNT_W-1:0]  cfg_tau,
    input  logic [CNT_W-1:0]  cfg_p2_len,
    input  logic [CNT_W-1:0]  cfg_acq_len,
    input  logic [CNT_W-1:0]  cfg_rep_dly,
    input  logic [SHOT_W-1:0] cfg_shots,
    input  logic [1:0]        cfg_p1_ph,
    input  logic [1:0]        cfg_p2_ph,
    input  logic              cfg_ph_cyc,
    output logic              enable,
    output logic [FRQ_W-1:0]  frq,
    output logic [1:0]        TX,
    output logic              acq_gate,
    output logic              busy,
    output logic              done,
    output logic [SHOT_W-1:0] shot_idx
);

    typedef logic [4:0][CNT_W-1:0] lens_t;

    state_e             state_q, state_d, nxt;
    logic [SHOT_W-1:0]  shot_q, shot_d;
    logic [FRQ_W-1:0]   frq_q, frq_d;
    lens_t              len_q, len_d;
    logic [SHOT_W-1:0]  shots_q, shots_d;
    logic [1:0]         p1_ph_q, p1_ph_d, p2_ph_q, p2_ph_d;
    logic               cyc_q, cyc_d;
    logic [SHOT_W:0]    eff_shots;
    logic               take, last, new_shot, load, expire, done_d;
    logic [CNT_W-1:0]   tlen;
    logic [1:0]         tx_d;

    // First non-empty state at or after 'first'; REP only counts mid-run.
    function automatic state_e seek(input logic [2:0] first,
                                    input logic       lst,
                                    input lens_t      l);
        state_e r;
        r = S_IDLE;
        if (first <= 3'd5 && !lst && l[4] != '0) r = S_REP;
        for (int i = 4; i >= 1; i--) begin
            if (3'(i) >= first && l[i-1] != '0) r = state_e'(3'(i));
        end
        return r;
    endfunction

    seq_timer #(.W(CNT_W)) u_timer (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .load_i  (load),
        .len_i   (tlen),
        .expire_o(expire)
    );

    always_comb begin
        take     = (state_q == S_IDLE) && start && !abort;
        frq_d    = take ? cfg_frq : frq_q;
        len_d    = take ? {cfg_rep_dly, cfg_acq_len, cfg_p2_len,
                           cfg_tau, cfg_p1_len} : len_q;
        shots_d  = take ? cfg_shots : shots_q;
        p1_ph_d  = take ? cfg_p1_ph : p1_ph_q;
        p2_ph_d  = take ? cfg_p2_ph : p2_ph_q;
        cyc_d    = take ? cfg_ph_cyc : cyc_q;
        eff_shots = (shots_d == '0) ? (SHOT_W+1)'(1) : {1'b0, shots_d};
        last     = ({1'b0, shot_q} + (SHOT_W+1)'(1)) >= eff_shots;
        state_d  = state_q;
        shot_d   = shot_q;
        nxt      = S_IDLE;
        new_shot = 1'b0;
        load     = 1'b0;
        tlen     = '0;
        done_d   = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else if (take) begin
            shot_d   = '0;
            new_shot = 1'b1;
        end else if (state_q != S_IDLE && expire) begin
            nxt = seek(3'(state_q) + 3'd1, last, len_d);
            if (nxt != S_IDLE) begin
                state_d = nxt;
                load    = 1'b1;
                tlen    = len_d[3'(nxt) - 3'd1];
            end else if (last) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else begin
                shot_d   = shot_q + SHOT_W'(1);
                new_shot = 1'b1;
            end
        end
        // An entirely empty shot still dwells one cycle (in REP).
        if (new_shot) begin
            nxt  = seek(3'd1, ({1'b0, shot_d} + (SHOT_W+1)'(1)) >= eff_shots,
                        len_d);
            load = 1'b1;
            if (nxt == S_IDLE) begin
                state_d = S_REP;
            end else begin
                state_d = nxt;
                tlen    = len_d[3'(nxt) - 3'd1];
            end
        end
        tx_d = PH_0;
        if (state_d == S_P1) tx_d = p1_ph_d + (cyc_d ? shot_d[1:0] : PH_0);
        if (state_d == S_P2) tx_d = p2_ph_d + (cyc_d ? shot_d[1:0] : PH_0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            shot_q   <= '0;
            frq_q    <= '0;
            len_q    <= '0;
            shots_q  <= '0;
            p1_ph_q  <= PH_0;
            p2_ph_q  <= PH_0;
            cyc_q    <= 1'b0;
            enable   <= 1'b0;
            frq      <= '0;
            TX       <= PH_0;
            acq_gate <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            shot_q   <= shot_d;
            frq_q    <= frq_d;
            len_q    <= len_d;
            shots_q  <= shots_d;
            p1_ph_q  <= p1_ph_d;
            p2_ph_q  <= p2_ph_d;
            cyc_q    <= cyc_d;
            enable   <= (state_d == S_P1) || (state_d == S_P2);
            frq      <= (state_d != S_IDLE) ? frq_d : '0;
            TX       <= tx_d;
            acq_gate <= (state_d == S_ACQ);
            busy     <= (state_d != S_IDLE);
            done     <= done_d;
        end
    end

    assign shot_idx = shot_q;

endmodule
